// File: rtl/fifo_pointer_control.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pointer_control
// Description : Read/write pointer, fill-count, status and sticky-error control
//               for a single-clock FIFO of 2**BUFFER_WIDTH entries.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_pointer_control #(
    parameter int BUFFER_WIDTH       = 3,
    parameter int BUFFER_SIZE        = 8,
    parameter int ALMOST_FULL_LEVEL  = 6,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write_Request,
    input  logic                    read_Request,
    input  logic                    clear_Errors,
    output logic                    write_Enable,
    output logic [BUFFER_WIDTH-1:0] write_Pointer,
    output logic [BUFFER_WIDTH-1:0] read_Pointer,
    output logic                    sig_Full,
    output logic                    sig_Empty,
    output logic                    sig_Almost_Full,
    output logic                    sig_Almost_Empty,
    output logic [BUFFER_WIDTH:0]   fill_Count,
    output logic                    read_Valid,
    output logic                    overflow_Error,
    output logic                    underflow_Error
);

    localparam logic [BUFFER_WIDTH:0]   c_SIZE    = (BUFFER_WIDTH+1)'(BUFFER_SIZE);
    localparam logic [BUFFER_WIDTH:0]   c_AF_LVL  = (BUFFER_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [BUFFER_WIDTH:0]   c_AE_LVL  = (BUFFER_WIDTH+1)'(ALMOST_EMPTY_LEVEL);
    localparam logic [BUFFER_WIDTH:0]   c_CNT_ONE = (BUFFER_WIDTH+1)'(1);
    localparam logic [BUFFER_WIDTH-1:0] c_PTR_ONE = BUFFER_WIDTH'(1);

    logic [BUFFER_WIDTH-1:0] r_wr_ptr;
    logic [BUFFER_WIDTH-1:0] r_rd_ptr;
    logic [BUFFER_WIDTH:0]   r_count;
    logic                    r_rd_valid;
    logic                    r_ovf_err;
    logic                    r_udf_err;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ovf_evt;
    logic w_udf_evt;

    // Status is a pure decode of the registered count, so it never glitches on requests.
    assign w_full    = (r_count == c_SIZE);
    assign w_empty   = (r_count == '0);
    assign w_wr_acc  = write_Request & ~w_full;
    assign w_rd_acc  = read_Request  & ~w_empty;
    assign w_ovf_evt = write_Request &  w_full;
    assign w_udf_evt = read_Request  &  w_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_rd_valid <= w_rd_acc;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            r_ovf_err <= w_ovf_evt | (r_ovf_err & ~clear_Errors);
            r_udf_err <= w_udf_evt | (r_udf_err & ~clear_Errors);
        end
    end

    assign write_Enable     = w_wr_acc;
    assign write_Pointer    = r_wr_ptr;
    assign read_Pointer     = r_rd_ptr;
    assign fill_Count       = r_count;
    assign sig_Full         = w_full;
    assign sig_Empty        = w_empty;
    assign sig_Almost_Full  = (r_count >= c_AF_LVL);
    assign sig_Almost_Empty = (r_count <= c_AE_LVL);
    assign read_Valid       = r_rd_valid;
    assign overflow_Error   = r_ovf_err;
    assign underflow_Error  = r_udf_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pointer_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_pointer_control
// Description : Directed self-checking bench for fifo_pointer_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_pointer_control;

    logic       clock;
    logic       reset;
    logic       write_Request;
    logic       read_Request;
    logic       clear_Errors;
    logic       write_Enable;
    logic [2:0] write_Pointer;
    logic [2:0] read_Pointer;
    logic       sig_Full;
    logic       sig_Empty;
    logic       sig_Almost_Full;
    logic       sig_Almost_Empty;
    logic [3:0] fill_Count;
    logic       read_Valid;
    logic       overflow_Error;
    logic       underflow_Error;

    int total = 0;
    int bad   = 0;

    fifo_pointer_control #(
        .BUFFER_WIDTH      (3),
        .BUFFER_SIZE       (8),
        .ALMOST_FULL_LEVEL (6),
        .ALMOST_EMPTY_LEVEL(2)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .write_Request   (write_Request),
        .read_Request    (read_Request),
        .clear_Errors    (clear_Errors),
        .write_Enable    (write_Enable),
        .write_Pointer   (write_Pointer),
        .read_Pointer    (read_Pointer),
        .sig_Full        (sig_Full),
        .sig_Empty       (sig_Empty),
        .sig_Almost_Full (sig_Almost_Full),
        .sig_Almost_Empty(sig_Almost_Empty),
        .fill_Count      (fill_Count),
        .read_Valid      (read_Valid),
        .overflow_Error  (overflow_Error),
        .underflow_Error (underflow_Error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge with the given requests; returns 1 ns after the edge.
    task automatic cyc(input logic w, input logic r, input logic c);
        write_Request = w;
        read_Request  = r;
        clear_Errors  = c;
        @(posedge clock);
        #1;
        write_Request = 1'b0;
        read_Request  = 1'b0;
        clear_Errors  = 1'b0;
    endtask

    // Full snapshot of every registered/decoded output against the reset state.
    task automatic test_reset_values(input string tag);
        logic [15:0] act;
        act = {write_Pointer, read_Pointer, fill_Count, read_Valid, overflow_Error,
               underflow_Error, sig_Full, sig_Empty, sig_Almost_Full, sig_Almost_Empty};
        total++;
        if (act !== 16'b000_000_0000_000_0101) begin
            bad++;
            $display("FAIL %s reset_state act=%b exp=%b", tag, act, 16'b000_000_0000_000_0101);
        end
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        write_Request = 1'b0;
        read_Request  = 1'b0;
        clear_Errors  = 1'b0;
        #2;
        test_reset_values("power_on");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        test_reset_values("post_release");
    endtask

    task automatic test_underflow;
        cyc(1'b0, 1'b1, 1'b0);
        total++;
        if ({read_Valid, read_Pointer, fill_Count, underflow_Error} !== {1'b0, 3'd0, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL underflow act=%b exp=%b",
                     {read_Valid, read_Pointer, fill_Count, underflow_Error}, {1'b0, 3'd0, 4'd0, 1'b1});
        end
        cyc(1'b0, 1'b1, 1'b1);
        total++;
        if (underflow_Error !== 1'b1) begin
            bad++;
            $display("FAIL udf_set_wins act=%b exp=1", underflow_Error);
        end
        cyc(1'b0, 1'b0, 1'b1);
        total++;
        if (underflow_Error !== 1'b0) begin
            bad++;
            $display("FAIL udf_clear act=%b exp=0", underflow_Error);
        end
    endtask

    task automatic test_fill;
        logic [3:0] exp_st;
        for (int i = 1; i <= 8; i++) begin
            write_Request = 1'b1;
            #1;
            total++;
            if (write_Enable !== 1'b1) begin
                bad++;
                $display("FAIL fill_we step=%0d act=%b exp=1", i, write_Enable);
            end
            cyc(1'b1, 1'b0, 1'b0);
            total++;
            if (fill_Count !== 4'(i) || write_Pointer !== 3'(i % 8)) begin
                bad++;
                $display("FAIL fill_cnt_ptr step=%0d act=%0d/%0d exp=%0d/%0d",
                         i, fill_Count, write_Pointer, i, i % 8);
            end
            exp_st = {(i == 8), 1'b0, (i >= 6), (i <= 2)};
            total++;
            if ({sig_Full, sig_Empty, sig_Almost_Full, sig_Almost_Empty} !== exp_st) begin
                bad++;
                $display("FAIL fill_status step=%0d act=%b exp=%b", i,
                         {sig_Full, sig_Empty, sig_Almost_Full, sig_Almost_Empty}, exp_st);
            end
        end
    endtask

    task automatic test_overflow;
        write_Request = 1'b1;
        #1;
        total++;
        if (write_Enable !== 1'b0) begin
            bad++;
            $display("FAIL ovf_we act=%b exp=0", write_Enable);
        end
        cyc(1'b1, 1'b0, 1'b0);
        total++;
        if ({fill_Count, write_Pointer, read_Pointer, overflow_Error} !== {4'd8, 3'd0, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL ovf_state act=%b exp=%b",
                     {fill_Count, write_Pointer, read_Pointer, overflow_Error}, {4'd8, 3'd0, 3'd0, 1'b1});
        end
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (overflow_Error !== 1'b1) begin
            bad++;
            $display("FAIL ovf_hold act=%b exp=1", overflow_Error);
        end
        cyc(1'b0, 1'b0, 1'b1);
        total++;
        if (overflow_Error !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear act=%b exp=0", overflow_Error);
        end
    endtask

    task automatic test_both_full;
        cyc(1'b1, 1'b1, 1'b0);
        total++;
        if ({fill_Count, sig_Full, overflow_Error, read_Valid, read_Pointer, write_Pointer}
                !== {4'd7, 1'b0, 1'b1, 1'b1, 3'd1, 3'd0}) begin
            bad++;
            $display("FAIL both_full act=%b exp=%b",
                     {fill_Count, sig_Full, overflow_Error, read_Valid, read_Pointer, write_Pointer},
                     {4'd7, 1'b0, 1'b1, 1'b1, 3'd1, 3'd0});
        end
        cyc(1'b0, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b1, 1'b0);
        total++;
        if ({fill_Count, read_Pointer, read_Valid} !== {4'd3, 3'd5, 1'b1}) begin
            bad++;
            $display("FAIL drain_to3 act=%b exp=%b", {fill_Count, read_Pointer, read_Valid}, {4'd3, 3'd5, 1'b1});
        end
    endtask

    task automatic test_back_to_back;
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if (read_Valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_valid act=%b exp=0", read_Valid);
        end
        cyc(1'b1, 1'b1, 1'b0);
        total++;
        if ({fill_Count, write_Pointer, read_Pointer, read_Valid} !== {4'd3, 3'd1, 3'd6, 1'b1}) begin
            bad++;
            $display("FAIL both_mid act=%b exp=%b",
                     {fill_Count, write_Pointer, read_Pointer, read_Valid}, {4'd3, 3'd1, 3'd6, 1'b1});
        end
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        total++;
        if ({fill_Count, write_Pointer, read_Pointer, sig_Empty, read_Valid} !== {4'd0, 3'd1, 3'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL drain_empty act=%b exp=%b",
                     {fill_Count, write_Pointer, read_Pointer, sig_Empty, read_Valid}, {4'd0, 3'd1, 3'd1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_both_empty;
        cyc(1'b1, 1'b1, 1'b0);
        total++;
        if ({fill_Count, underflow_Error, read_Valid, write_Pointer, read_Pointer}
                !== {4'd1, 1'b1, 1'b0, 3'd2, 3'd1}) begin
            bad++;
            $display("FAIL both_empty act=%b exp=%b",
                     {fill_Count, underflow_Error, read_Valid, write_Pointer, read_Pointer},
                     {4'd1, 1'b1, 1'b0, 3'd2, 3'd1});
        end
    endtask

    task automatic test_async_reset;
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        total++;
        if ({fill_Count, write_Pointer, read_Valid} !== {4'd5, 3'd6, 1'b0}) begin
            bad++;
            $display("FAIL pre_reset act=%b exp=%b", {fill_Count, write_Pointer, read_Valid}, {4'd5, 3'd6, 1'b0});
        end
        #3;
        reset = 1'b1;
        #1;
        test_reset_values("mid_cycle");
        #2;
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        total++;
        if ({fill_Count, write_Pointer, read_Pointer, underflow_Error} !== {4'd1, 3'd1, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_write act=%b exp=%b",
                     {fill_Count, write_Pointer, read_Pointer, underflow_Error}, {4'd1, 3'd1, 3'd0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_fill();
        test_overflow();
        test_both_full();
        test_back_to_back();
        test_both_empty();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_pointer_control.md
FIFO_POINTER_CONTROL -- requirements
Module: fifo_pointer_control

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- BUFFER_WIDTH, 3, pointer width in bits.
- BUFFER_SIZE, 8, number of entries; SHALL equal 2**BUFFER_WIDTH.
- ALMOST_FULL_LEVEL, 6, fill count at or above which sig_Almost_Full is asserted.
- ALMOST_EMPTY_LEVEL, 2, fill count at or below which sig_Almost_Empty is asserted.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- write_Request, in, 1, producer requests a push this cycle.
- read_Request, in, 1, consumer requests a pop this cycle.
- clear_Errors, in, 1, synchronous clear of the sticky error flags.
- write_Enable, out, 1, write strobe to the storage array.
- write_Pointer, out, BUFFER_WIDTH, storage address of the next write.
- read_Pointer, out, BUFFER_WIDTH, storage address of the next read.
- sig_Full, out, 1, fill count equals BUFFER_SIZE.
- sig_Empty, out, 1, fill count equals 0.
- sig_Almost_Full, out, 1, fill count >= ALMOST_FULL_LEVEL.
- sig_Almost_Empty, out, 1, fill count <= ALMOST_EMPTY_LEVEL.
- fill_Count, out, BUFFER_WIDTH+1, number of stored entries, 0..BUFFER_SIZE.
- read_Valid, out, 1, storage output data is valid this cycle.
- overflow_Error, out, 1, sticky flag: a write was refused.
- underflow_Error, out, 1, sticky flag: a read was refused.

Function
REQ-003 A write SHALL be accepted when write_Request=1 and sig_Full=0; a read SHALL be accepted when read_Request=1 and sig_Empty=0, both evaluated on the pre-edge state.
REQ-004 write_Enable SHALL be combinational and equal write_Request AND NOT sig_Full.
REQ-005 On an accepted write, write_Pointer SHALL increment by 1 modulo BUFFER_SIZE (wrap BUFFER_SIZE-1 -> 0) at the same edge.
REQ-006 On an accepted read, read_Pointer SHALL increment by 1 modulo BUFFER_SIZE at the same edge.
REQ-007 The storage array registers data[read_Pointer] on every edge, so read_Valid SHALL be a register set to 1 on the edge that accepts a read and cleared on any edge with no accepted read; latency from accepted request to valid data is one cycle.
REQ-008 fill_Count SHALL update as follows:
- +1 on a write-only accept.
- -1 on a read-only accept.
- unchanged when both or neither are accepted.
- never below 0 or above BUFFER_SIZE.
REQ-009 sig_Full, sig_Empty, sig_Almost_Full and sig_Almost_Empty SHALL be decoded combinationally from the registered fill_Count only.
REQ-010 With both requests active and count=BUFFER_SIZE: the read SHALL be accepted, the write refused, and count becomes BUFFER_SIZE-1.
REQ-011 With both requests active and count=0: the write SHALL be accepted, the read refused, and count becomes 1 (no read-through of the written data).
REQ-012 With both requests active and 0<count<BUFFER_SIZE: both SHALL be accepted, both pointers advance, and count is unchanged.
REQ-013 overflow_Error SHALL be set at the edge where write_Request=1 and sig_Full=1; underflow_Error SHALL be set at the edge where read_Request=1 and sig_Empty=1.
REQ-014 Both error flags SHALL stay set until clear_Errors=1 at a clock edge.
REQ-015 If clear_Errors coincides with a new error event, that flag SHALL end up set (set wins).
REQ-016 Refused requests SHALL NOT change the pointers, fill_Count or read_Valid.
REQ-017 When fill_Count=0, write_Pointer SHALL equal read_Pointer; when fill_Count=BUFFER_SIZE, write_Pointer SHALL also equal read_Pointer, with fill_Count alone distinguishing full from empty.

Reset
REQ-018 While reset=1, independent of clock, outputs SHALL be:
- write_Pointer=0, read_Pointer=0, fill_Count=0.
- read_Valid=0, overflow_Error=0, underflow_Error=0.
- hence sig_Empty=1, sig_Almost_Empty=1, sig_Full=0, sig_Almost_Full=0.
REQ-019 Reset asserted mid-operation SHALL discard all pending state; the first edge after deassertion SHALL act on requests normally.

Verification
REQ-020 After reset, 8 consecutive write-only cycles -> fill_Count steps 1..8, sig_Almost_Full rises at count 6, sig_Full=1 at count 8, write_Pointer wraps back to 0.
REQ-021 Full FIFO plus one more write_Request -> write_Enable=0, pointers and count unchanged, overflow_Error=1 and held; then clear_Errors pulse -> overflow_Error=0.
REQ-022 Empty FIFO plus read_Request -> read_Valid=0, read_Pointer=0, underflow_Error=1.
REQ-023 Count=3 with simultaneous read and write -> count stays 3, both pointers +1, read_Valid=1 in the next cycle.
REQ-024 Count=8 with simultaneous read and write -> count=7, sig_Full=0, overflow_Error=1, read_Valid=1; count=0 with both requests -> count=1, underflow_Error=1, read_Valid=0.
REQ-025 Reset pulsed between clock edges at count=5 -> all outputs at reset values immediately, before the next edge.
